scope_capture_ctrl: RTL and testbench
=====================================

// Module: scope_capture_ctrl
// PURPOSE
//  Parametrised oscilloscope capture controller; next generation of the ctrl block.
//  Stores ADC samples in a circular buffer with configurable pre-trigger depth.
//  Detects a level/edge trigger (or a forced trigger), then streams the captured window
//  as bytes to the UART transmitter over a valid/ready handshake, oldest sample first.
// PARAMETERS
//  DATA_W  8    sample width, 1..16; each sample is sent as NB=ceil(DATA_W/8) bytes
//  DEPTH   256  capture window in samples, power of 2, >=4
//  PTR_W   $clog2(DEPTH)  buffer address width (derived, not overridden)
// PORTS
//  clk         in   1       single clock; all logic synchronous to it
//  rst_n       in   1       asynchronous, active-low reset
//  smp_valid   in   1       smp_data holds a new sample this cycle
//  smp_data    in   DATA_W  ADC sample, unsigned
//  arm         in   1       1-cycle request to start a capture; honoured only in IDLE
//  abort       in   1       cancel the capture; return to IDLE
//  force_trig  in   1       trigger without a level crossing (WAIT_TRIG only)
//  trig_level  in   DATA_W  trigger threshold, unsigned
//  trig_edge   in   1       0 = rising, 1 = falling
//  pre_len     in   PTR_W   pre-trigger samples in the window; latched on arm
//  tx_data     out  8       byte to the UART TX
//  tx_valid    out  1       tx_data is valid
//  tx_ready    in   1       UART accepts the byte when tx_valid&&tx_ready
//  state_o     out  3       IDLE=0 PRE=1 WAIT_TRIG=2 POST=3 DUMP=4
//  busy        out  1       state_o!=IDLE
//  done        out  1       1-cycle pulse after the last byte of a dump is accepted
// BEHAVIOUR
//  Reset: state IDLE; wr_ptr=0; counters 0; tx_valid=0; tx_data=0; busy=0; done=0.
//    Reset is legal at any time, including mid-DUMP; the partial dump is dropped.
//  IDLE: on arm, latch pre_len and clear prev_ok. Go to PRE, or to WAIT_TRIG if pre_len==0.
//  Write rule (PRE/WAIT_TRIG/POST): each smp_valid writes mem[wr_ptr] and increments wr_ptr mod DEPTH.
//    Samples are ignored in IDLE and DUMP.
//  PRE: count valid samples; after pre_len writes, go to WAIT_TRIG. No trigger is evaluated here.
//  WAIT_TRIG: keep writing; the buffer wraps and overwrites the oldest entries.
//    Rising trigger: prev_ok && prev<trig_level && smp_data>=trig_level, on a valid sample.
//    Falling trigger: prev_ok && prev>trig_level && smp_data<=trig_level, on a valid sample.
//    prev holds the last valid sample; prev_ok is set by the first valid sample after arm.
//    The trigger sample is the first post sample.
//    force_trig: the first valid sample in the same or any later cycle is the trigger sample.
//    Go to POST after writing the trigger sample.
//  POST: total post samples = DEPTH-pre_len, trigger sample included.
//    After the last one is written, go to DUMP; rd_ptr = wr_ptr (the oldest entry).
//  Window guarantee: the dump holds exactly pre_len samples before the trigger sample,
//    followed by DEPTH-pre_len samples from the trigger onwards. All samples are contiguous.
//  DUMP: DEPTH samples from rd_ptr, with wrap; per sample NB bytes, MSB byte first;
//    the upper byte is zero-padded.
//    The buffer uses synchronous read (1 cycle). The first tx_valid is raised <=3 cycles after entering DUMP.
//    Handshake: once raised, tx_valid stays high and tx_data stays stable until tx_valid&&tx_ready.
//    Max rate is 1 byte/cycle. After the final accept: tx_valid=0, done=1 for one cycle, state IDLE.
//  abort: any non-IDLE state goes to IDLE on the next edge; tx_valid=0 (abort overrides the handshake).
//    Counters are cleared; there is no done pulse. Simultaneous arm&&abort in IDLE: abort wins and stays IDLE.
//  arm outside IDLE is ignored. pre_len changes after arm have no effect until the next arm.
// TESTING (bench overrides DEPTH=16)
//  1 pre_len=4, rising, level=20, ramp 0,1,2.. every cycle -> 16 bytes 16..31, then done pulse.
//  2 falling, level=0x40, ramp down from 0xFF; random tx_ready (50%).
//    -> bytes 0x43..0x34 in order; tx_data stable while stalled.
//  3 pre_len=0, constant input 0x55, force_trig at cycle k -> 16 bytes of 0x55; no rising trigger fires.
//  4 abort during POST -> state_o=0 and tx_valid=0 next cycle; a new arm re-captures correctly.
//  5 DATA_W=12, trigger sample 0xABC -> its bytes are 0x0A then 0xBC; dump is 32 bytes.
//  6 rst_n low mid-DUMP -> all outputs at reset values immediately (async); next arm works.

Source files
------------

// File: rtl/scope_capture_ctrl_if.sv
// Bundle between the scope capture controller and its environment: sample input,
// capture controls, and the byte stream towards the UART transmitter.
interface scope_capture_ctrl_if #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 256
);
  localparam int PTR_W = $clog2(DEPTH);

  logic              smp_valid;
  logic [DATA_W-1:0] smp_data;
  logic              arm;
  logic              abort;
  logic              force_trig;
  logic [DATA_W-1:0] trig_level;
  logic              trig_edge;
  logic [PTR_W-1:0]  pre_len;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic [2:0]        state_o;
  logic              busy;
  logic              done;

  modport master (
    output smp_valid, smp_data, arm, abort, force_trig, trig_level, trig_edge, pre_len, tx_ready,
    input  tx_data, tx_valid, state_o, busy, done
  );

  modport slave (
    input  smp_valid, smp_data, arm, abort, force_trig, trig_level, trig_edge, pre_len, tx_ready,
    output tx_data, tx_valid, state_o, busy, done
  );
endinterface

// File: rtl/scope_capture_ctrl.sv
// Oscilloscope capture controller: circular sample buffer with pre-trigger depth,
// level/edge or forced trigger, then a byte-serial dump of the window, oldest first.
module scope_capture_ctrl #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic                clk,
  input  logic                rst_n,
  scope_capture_ctrl_if.slave bus
);
  localparam int             PTR_W   = $clog2(DEPTH);
  localparam int             NB      = (DATA_W + 7) / 8;
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);
  localparam logic           BYTE_HI = (NB > 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PRE  = 3'd1,
    S_WAIT = 3'd2,
    S_POST = 3'd3,
    S_DUMP = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  pre_len_q, pre_len_d;
  logic [PTR_W:0]    cnt_q, cnt_d;
  logic [PTR_W:0]    rd_cnt_q, rd_cnt_d;
  logic [DATA_W-1:0] prev_q, prev_d;
  logic [DATA_W-1:0] smp_q, smp_d;
  logic              prev_ok_q, prev_ok_d;
  logic              force_pend_q, force_pend_d;
  logic              rd_inflight_q, rd_inflight_d;
  logic              smp_vld_q, smp_vld_d;
  logic              byte_idx_q, byte_idx_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              tx_valid_q, tx_valid_d;
  logic              done_q, done_d;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] mem_rd_q;
  logic [PTR_W-1:0]  rd_addr;
  logic [PTR_W:0]    post_total;
  logic [15:0]       pad;
  logic              we, level_hit, tx_free;

  always_comb begin
    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q;
    pre_len_d     = pre_len_q;
    cnt_d         = cnt_q;
    rd_cnt_d      = rd_cnt_q;
    prev_d        = prev_q;
    smp_d         = smp_q;
    prev_ok_d     = prev_ok_q;
    force_pend_d  = force_pend_q;
    rd_inflight_d = rd_inflight_q;
    smp_vld_d     = smp_vld_q;
    byte_idx_d    = byte_idx_q;
    tx_data_d     = tx_data_q;
    tx_valid_d    = tx_valid_q;
    done_d        = 1'b0;
    we            = 1'b0;
    rd_addr       = wr_ptr_q + rd_cnt_q[PTR_W-1:0];
    post_total    = DEPTH_C - {1'b0, pre_len_q};
    tx_free       = !tx_valid_q || bus.tx_ready;
    pad           = '0;
    pad[DATA_W-1:0] = smp_q;
    level_hit     = prev_ok_q &&
                    (bus.trig_edge ? (prev_q > bus.trig_level && bus.smp_data <= bus.trig_level)
                                   : (prev_q < bus.trig_level && bus.smp_data >= bus.trig_level));

    unique case (state_q)
      S_IDLE: begin
        if (bus.arm && !bus.abort) begin
          pre_len_d    = bus.pre_len;
          prev_ok_d    = 1'b0;
          force_pend_d = 1'b0;
          cnt_d        = '0;
          state_d      = (bus.pre_len == '0) ? S_WAIT : S_PRE;
        end
      end
      S_PRE: begin
        if (bus.smp_valid) begin
          we    = 1'b1;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q + 1'b1 == {1'b0, pre_len_q}) begin
            cnt_d   = '0;
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        // A force request waits here for the next valid sample to become the trigger.
        if (bus.force_trig) force_pend_d = 1'b1;
        if (bus.smp_valid) begin
          we = 1'b1;
          if (force_pend_q || bus.force_trig || level_hit) begin
            force_pend_d = 1'b0;
            cnt_d        = (PTR_W+1)'(1);
            state_d      = (post_total == (PTR_W+1)'(1)) ? S_DUMP : S_POST;
          end
        end
      end
      S_POST: begin
        if (bus.smp_valid) begin
          we    = 1'b1;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q + 1'b1 == post_total) begin
            cnt_d   = '0;
            state_d = S_DUMP;
          end
        end
      end
      S_DUMP: begin
        // The oldest entry sits at wr_ptr; one read in flight feeds a one-sample serializer.
        if (rd_inflight_q) begin
          smp_d         = mem_rd_q;
          smp_vld_d     = 1'b1;
          byte_idx_d    = BYTE_HI;
          rd_inflight_d = 1'b0;
        end else if (!smp_vld_q && rd_cnt_q != DEPTH_C) begin
          rd_inflight_d = 1'b1;
          rd_cnt_d      = rd_cnt_q + 1'b1;
        end
        if (smp_vld_q && tx_free) begin
          tx_data_d  = byte_idx_q ? pad[15:8] : pad[7:0];
          tx_valid_d = 1'b1;
          if (byte_idx_q) byte_idx_d = 1'b0;
          else            smp_vld_d  = 1'b0;
        end else if (tx_valid_q && bus.tx_ready) begin
          tx_valid_d = 1'b0;
        end
        if (tx_valid_q && bus.tx_ready && !smp_vld_q && !rd_inflight_q && rd_cnt_q == DEPTH_C) begin
          done_d   = 1'b1;
          rd_cnt_d = '0;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (we) begin
      wr_ptr_d  = wr_ptr_q + 1'b1;
      prev_d    = bus.smp_data;
      prev_ok_d = 1'b1;
    end

    if (bus.abort && state_q != S_IDLE) begin
      state_d       = S_IDLE;
      we            = 1'b0;
      wr_ptr_d      = wr_ptr_q;
      cnt_d         = '0;
      rd_cnt_d      = '0;
      rd_inflight_d = 1'b0;
      smp_vld_d     = 1'b0;
      force_pend_d  = 1'b0;
      tx_valid_d    = 1'b0;
      done_d        = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      wr_ptr_q      <= '0;
      pre_len_q     <= '0;
      cnt_q         <= '0;
      rd_cnt_q      <= '0;
      prev_ok_q     <= 1'b0;
      force_pend_q  <= 1'b0;
      rd_inflight_q <= 1'b0;
      smp_vld_q     <= 1'b0;
      byte_idx_q    <= 1'b0;
      tx_data_q     <= '0;
      tx_valid_q    <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      pre_len_q     <= pre_len_d;
      cnt_q         <= cnt_d;
      rd_cnt_q      <= rd_cnt_d;
      prev_ok_q     <= prev_ok_d;
      force_pend_q  <= force_pend_d;
      rd_inflight_q <= rd_inflight_d;
      smp_vld_q     <= smp_vld_d;
      byte_idx_q    <= byte_idx_d;
      tx_data_q     <= tx_data_d;
      tx_valid_q    <= tx_valid_d;
      done_q        <= done_d;
    end
  end

  // Sample storage and data-only holding registers; their contents are qualified by control flops.
  always_ff @(posedge clk) begin
    if (we) mem[wr_ptr_q] <= bus.smp_data;
    mem_rd_q <= mem[rd_addr];
    prev_q   <= prev_d;
    smp_q    <= smp_d;
  end

  assign bus.tx_data  = tx_data_q;
  assign bus.tx_valid = tx_valid_q;
  assign bus.state_o  = state_q;
  assign bus.busy     = (state_q != S_IDLE);
  assign bus.done     = done_q;
endmodule

// File: tb/tb_scope_capture_ctrl.sv
// Bench for scope_capture_ctrl: a window model derived from the sample history
// feeds an expected byte queue that a single per-cycle compare process checks.
module tb_scope_capture_ctrl;
  localparam int DEPTH = 16;

  logic        clk, rst_n, sel;
  logic        smp_valid_t, arm_t, abort_t, force_t, edge_t, ready_t;
  logic [15:0] smp_data_t, level_t;
  logic [3:0]  pre_len_t;

  scope_capture_ctrl_if #(.DATA_W(8),  .DEPTH(DEPTH)) b8  ();
  scope_capture_ctrl_if #(.DATA_W(12), .DEPTH(DEPTH)) b12 ();

  scope_capture_ctrl #(.DATA_W(8),  .DEPTH(DEPTH)) u8  (.clk(clk), .rst_n(rst_n), .bus(b8.slave));
  scope_capture_ctrl #(.DATA_W(12), .DEPTH(DEPTH)) u12 (.clk(clk), .rst_n(rst_n), .bus(b12.slave));

  assign b8.smp_valid   = smp_valid_t & ~sel;
  assign b8.smp_data    = smp_data_t[7:0];
  assign b8.arm         = arm_t & ~sel;
  assign b8.abort       = abort_t & ~sel;
  assign b8.force_trig  = force_t & ~sel;
  assign b8.trig_level  = level_t[7:0];
  assign b8.trig_edge   = edge_t;
  assign b8.pre_len     = pre_len_t;
  assign b8.tx_ready    = ready_t & ~sel;
  assign b12.smp_valid  = smp_valid_t & sel;
  assign b12.smp_data   = smp_data_t[11:0];
  assign b12.arm        = arm_t & sel;
  assign b12.abort      = abort_t & sel;
  assign b12.force_trig = force_t & sel;
  assign b12.trig_level = level_t[11:0];
  assign b12.trig_edge  = edge_t;
  assign b12.pre_len    = pre_len_t;
  assign b12.tx_ready   = ready_t & sel;

  logic [7:0] o_tx_data;
  logic [2:0] o_state;
  logic       o_tx_valid, o_busy, o_done;
  assign o_tx_data  = sel ? b12.tx_data  : b8.tx_data;
  assign o_tx_valid = sel ? b12.tx_valid : b8.tx_valid;
  assign o_state    = sel ? b12.state_o  : b8.state_o;
  assign o_busy     = sel ? b12.busy     : b8.busy;
  assign o_done     = sel ? b12.done     : b8.done;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         total = 0;
  int         bad   = 0;
  int         stim[$];
  logic [7:0] expq[$];
  logic [7:0] gotq[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    end
  endtask

  // Index of the trigger sample among the valid samples after arm, or -1.
  function automatic int find_trig(input int pre, input int lvl, input bit fall, input int fk);
    for (int i = pre; i < stim.size(); i++) begin
      if (fk >= 0 && fk >= pre && i >= fk) return i;
      if (i >= 1) begin
        if (!fall && stim[i-1] < lvl && stim[i] >= lvl) return i;
        if (fall && stim[i-1] > lvl && stim[i] <= lvl) return i;
      end
    end
    return -1;
  endfunction

  function automatic void build_exp(input int pre, input int trig, input bit two);
    expq.delete();
    if (trig < 0) return;
    for (int j = trig - pre; j < trig - pre + DEPTH; j++) begin
      if (two) expq.push_back(8'((stim[j] >> 8) & 255));
      expq.push_back(8'(stim[j] & 255));
    end
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_cap(input bit s, input int pre, input int lvl, input bit fall,
                         input int fk, input bit rnd_rdy, input bit no_trig_chk);
    int idx;
    int cyc;
    sel = s;
    build_exp(pre, find_trig(pre, lvl, fall, fk), s);
    gotq.delete();
    pre_len_t = 4'(pre); level_t = 16'(lvl); edge_t = fall;
    smp_valid_t = 1'b0; arm_t = 1'b1;
    step();
    arm_t = 1'b0;
    chk("armed_state", o_state, (pre == 0) ? 2 : 1);
    pre_len_t = 4'(pre) ^ 4'hA;
    idx = 0;
    cyc = 0;
    while (!o_done && cyc < 2000) begin
      smp_valid_t = (idx < stim.size());
      smp_data_t  = (idx < stim.size()) ? 16'(stim[idx]) : 16'h0;
      force_t     = (idx == fk);
      if (no_trig_chk && idx == fk) chk("no_level_trig_before_force", o_state, 2);
      ready_t     = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      idx++;
      cyc++;
      step();
    end
    smp_valid_t = 1'b0; force_t = 1'b0; ready_t = 1'b0;
    chk("done_seen", o_done, 1);
    chk("all_bytes_sent", expq.size(), 0);
    step();
  endtask

  bit         done_exp, hold, abort_d, seen_v;
  logic [7:0] hold_data;
  int         dump_age;

  always @(negedge clk) begin
    if (!rst_n) begin
      done_exp = 1'b0; hold = 1'b0; seen_v = 1'b0; dump_age = 0;
    end else begin
      chk("done", o_done, done_exp);
      if (done_exp) chk("idle_after_done", {o_tx_valid, o_state}, 0);
      done_exp = 1'b0;
      chk("busy", o_busy, (o_state != 3'd0));
      if (hold && !abort_d) begin
        chk("stall_valid", o_tx_valid, 1);
        chk("stall_data", o_tx_data, hold_data);
      end
      if (o_state == 3'd4) begin
        if (!seen_v && o_tx_valid) begin
          chk("first_valid_latency_ok", (dump_age <= 3), 1);
          seen_v = 1'b1;
        end
        dump_age++;
      end else begin
        dump_age = 0; seen_v = 1'b0;
      end
      if (o_tx_valid && ready_t) begin
        gotq.push_back(o_tx_data);
        if (expq.size() == 0) begin
          total++; bad++;
          $display("FAIL extra_byte: got 0x%0h with no byte expected", o_tx_data);
        end else begin
          chk("byte", o_tx_data, expq.pop_front());
          if (expq.size() == 0) done_exp = 1'b1;
        end
      end
      hold      = o_tx_valid && !ready_t;
      hold_data = o_tx_data;
      abort_d   = abort_t;
    end
  end

  initial begin
    int n;
    sel = 1'b0; rst_n = 1'b0;
    smp_valid_t = 1'b0; arm_t = 1'b0; abort_t = 1'b0; force_t = 1'b0;
    edge_t = 1'b0; ready_t = 1'b0; smp_data_t = '0; level_t = '0; pre_len_t = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", o_state, 0);
    chk("rst_tx_valid", o_tx_valid, 0);
    chk("rst_tx_data", o_tx_data, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_done", o_done, 0);
    rst_n = 1'b1;
    step();

    stim.delete();
    for (int i = 0; i < 64; i++) stim.push_back(i);
    chk("model_t1_trig", find_trig(4, 20, 0, -1), 20);
    run_cap(0, 4, 20, 0, -1, 0, 0);
    chk("t1_count", gotq.size(), 16);
    chk("t1_first", gotq[0], 16);
    chk("t1_last", gotq[15], 31);

    stim.delete();
    for (int i = 0; i < 220; i++) stim.push_back(255 - i);
    chk("model_t2_trig", find_trig(3, 'h40, 1, -1), 191);
    run_cap(0, 3, 'h40, 1, -1, 1, 0);
    chk("t2_first", gotq[0], 'h43);
    chk("t2_trig_byte", gotq[3], 'h40);
    chk("t2_last", gotq[15], 'h34);

    stim.delete();
    for (int i = 0; i < 40; i++) stim.push_back('h55);
    chk("model_t3_trig", find_trig(0, 'h55, 0, 5), 5);
    run_cap(0, 0, 'h55, 0, 5, 0, 1);
    chk("t3_count", gotq.size(), 16);
    chk("t3_byte", gotq[9], 'h55);

    stim.delete();
    for (int i = 0; i < 128; i++) stim.push_back(i);
    sel = 1'b0; pre_len_t = 4'd4; level_t = 16'd20; edge_t = 1'b0;
    arm_t = 1'b1;
    step();
    arm_t = 1'b0;
    for (int i = 0; i < 24; i++) begin
      smp_valid_t = 1'b1; smp_data_t = 16'(i);
      step();
    end
    chk("t4_in_post", o_state, 3);
    smp_data_t = 16'd24; abort_t = 1'b1;
    step();
    abort_t = 1'b0; smp_valid_t = 1'b0;
    chk("t4_abort_state", o_state, 0);
    chk("t4_abort_valid", o_tx_valid, 0);
    chk("t4_abort_busy", o_busy, 0);
    arm_t = 1'b1; abort_t = 1'b1;
    step();
    arm_t = 1'b0; abort_t = 1'b0;
    chk("t4_arm_abort_idle", o_state, 0);
    repeat (3) step();
    run_cap(0, 8, 100, 0, -1, 0, 0);
    chk("t4_first", gotq[0], 92);
    chk("t4_last", gotq[15], 107);

    stim.delete();
    for (int i = 0; i < 40; i++) stim.push_back('hAB0 + i);
    run_cap(1, 4, 'hABC, 0, -1, 0, 0);
    chk("t5_count", gotq.size(), 32);
    chk("t5_first_hi", gotq[0], 'h0A);
    chk("t5_first_lo", gotq[1], 'hB8);
    chk("t5_trig_hi", gotq[8], 'h0A);
    chk("t5_trig_lo", gotq[9], 'hBC);

    stim.delete();
    for (int i = 0; i < 64; i++) stim.push_back(i);
    sel = 1'b0; pre_len_t = 4'd4; level_t = 16'd20; edge_t = 1'b0; ready_t = 1'b0;
    arm_t = 1'b1;
    step();
    arm_t = 1'b0;
    n = 0;
    while (!(o_state == 3'd4 && o_tx_valid) && n < 200) begin
      smp_valid_t = 1'b1; smp_data_t = 16'(n);
      n++;
      step();
    end
    smp_valid_t = 1'b0;
    chk("t6_dump_reached", o_tx_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_state", o_state, 0);
    chk("t6_rst_valid", o_tx_valid, 0);
    chk("t6_rst_data", o_tx_data, 0);
    chk("t6_rst_busy", o_busy, 0);
    chk("t6_rst_done", o_done, 0);
    expq.delete();
    step();
    rst_n = 1'b1;
    step();
    run_cap(0, 4, 20, 0, -1, 1, 0);
    chk("t6_rearm_first", gotq[0], 16);
    chk("t6_rearm_last", gotq[15], 31);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
